spi_master_seq: RTL and testbench

- Transaction sequencer for the SPI transmit datapath; mode 0 (CPOL=0, CPHA=0), MSB first.
- Generates SCLK and CS_n, fetches bytes from an upstream valid/ready stream, and drives the shift block's load, enable and parallel data.
- Uses the shift block's done flag to step through a multi-byte frame.
- Sits between the DAQ command logic and the SPI pins.

---
 rtl/spi_master_seq.sv | 184 ++++++++++++++++++
 tb/tb_spi_master_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_seq.sv
// Purpose: SPI mode-0 transmit sequencer that frames CS_n, generates SCLK and feeds the shift block one word at a time.
// Latency: every output is registered; CS_n falls and busy rises one clock after start is accepted; done pulses one clock after the last hold clock.
// Backpressure: data_ready_o is high only in FETCH; with data_valid_i low the frame stalls there indefinitely with CS_n low and SCLK idle.
//
// Ports:
//   clock_i, reset_ni                       system clock, asynchronous active-low reset
//   start_i, num_words_i                    frame request and length, sampled only in IDLE
//   data_valid_i, data_i, data_ready_o      upstream word stream (valid/ready)
//   busy_o, done_o, words_sent_o            frame status
//   SCLK_o, CS_n_o                          SPI pins (SCLK idles low)
//   tx_en_o, tx_load_o, tx_buffer_o         shift-block control and parallel data
//   tx_done_i                               shift block has seen WIDTH falling edges
//
// CS_SETUP and CS_HOLD must be at least 1; CLK_DIV must be at least 2.
module spi_master_seq #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter int MAX_WORDS = 16,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                           clock_i,
  input  logic                           reset_ni,
  input  logic                           start_i,
  input  logic [$clog2(MAX_WORDS+1)-1:0] num_words_i,
  input  logic                           data_valid_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic                           data_ready_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(MAX_WORDS+1)-1:0] words_sent_o,
  output logic                           SCLK_o,
  output logic                           CS_n_o,
  output logic                           tx_en_o,
  output logic                           tx_load_o,
  output logic [WIDTH-1:0]               tx_buffer_o,
  input  logic                           tx_done_i
);

  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);
  localparam int EW = $clog2(2 * WIDTH);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * WIDTH - 1);
  localparam logic [NW-1:0] MAX_LEN    = NW'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_FETCH, S_LOAD, S_SHIFT, S_WAIT, S_GAP, S_HOLD, S_END
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // shared by SETUP and HOLD
  logic [DW-1:0]   div_q, div_d;     // SCLK half-period divider
  logic [EW-1:0]   edge_q, edge_d;   // SCLK toggles emitted for this word
  logic [NW-1:0]   len_q, len_d;
  logic [NW-1:0]   words_d;
  logic [WIDTH-1:0] buf_d;
  logic            sclk_d, zero_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    edge_d    = edge_q;
    len_d     = len_q;
    words_d   = words_sent_o;
    buf_d     = tx_buffer_o;
    sclk_d    = 1'b0;
    zero_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          words_d = '0;
          if (num_words_i == '0) begin
            zero_done = 1'b1;
          end else begin
            len_d   = (num_words_i > MAX_LEN) ? MAX_LEN : num_words_i;
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH: begin
        if (data_valid_i && data_ready_o) begin
          buf_d   = data_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        edge_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sclk_d = SCLK_o;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~SCLK_o;
          // The last toggle is the WIDTH-th falling edge; SCLK parks low.
          if (edge_q == EDGE_LAST) begin
            sclk_d  = 1'b0;
            state_d = S_WAIT;
          end else begin
            edge_d = edge_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if (words_sent_o != MAX_LEN) words_d = words_sent_o + 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (words_sent_o < len_q) begin
          state_d = S_FETCH;
        end else begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      edge_q       <= '0;
      len_q        <= '0;
      words_sent_o <= '0;
      tx_buffer_o  <= '0;
      SCLK_o       <= 1'b0;
      CS_n_o       <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      data_ready_o <= 1'b0;
      tx_load_o    <= 1'b0;
      tx_en_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      edge_q       <= edge_d;
      len_q        <= len_d;
      words_sent_o <= words_d;
      tx_buffer_o  <= buf_d;
      SCLK_o       <= sclk_d;
      CS_n_o       <= (state_d == S_IDLE) || (state_d == S_END);
      busy_o       <= (state_d != S_IDLE) && (state_d != S_END);
      done_o       <= (state_d == S_END) || zero_done;
      data_ready_o <= (state_d == S_FETCH);
      tx_load_o    <= (state_d == S_LOAD);
      tx_en_o      <= (state_d == S_SHIFT) || (state_d == S_WAIT);
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Purpose: randomized and directed stimulus for spi_master_seq with a scoreboard of expected words and frame lengths.
// Latency: a monitor reassembles MOSI bytes at SCLK rising edges and checks frame totals at each done pulse.
// Backpressure: the upstream source randomly drops data_valid_i, with forced stalls between words in one case.
module tb_spi_master_seq;
  localparam int W  = 8;
  localparam int CD = 4;
  localparam int MW = 16;
  localparam int NW = $clog2(MW + 1);

  logic          clock_i = 1'b0;
  logic          reset_ni, start_i, data_valid_i, tx_done_i;
  logic [NW-1:0] num_words_i, words_sent_o;
  logic [W-1:0]  data_i, tx_buffer_o;
  logic          data_ready_o, busy_o, done_o, SCLK_o, CS_n_o, tx_en_o, tx_load_o;

  always #5 clock_i = ~clock_i;

  spi_master_seq #(.WIDTH(W), .CLK_DIV(CD), .MAX_WORDS(MW), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .start_i(start_i), .num_words_i(num_words_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .busy_o(busy_o), .done_o(done_o), .words_sent_o(words_sent_o),
    .SCLK_o(SCLK_o), .CS_n_o(CS_n_o), .tx_en_o(tx_en_o), .tx_load_o(tx_load_o),
    .tx_buffer_o(tx_buffer_o), .tx_done_i(tx_done_i)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_words[$];   // words accepted upstream, in serial order
  int           exp_frames[$];  // expected word count of each frame
  logic [W-1:0] src_q[$];       // directed words for the source
  int           stall_left = 0;
  int           stall_pct  = 0;
  int           rises_in_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Upstream source: holds each word until accepted, pushes it to the scoreboard on handshake.
  initial begin
    logic [W-1:0] cur;
    logic         have;
    have = 1'b0;
    cur = '0;
    data_valid_i = 1'b0;
    data_i = '0;
    forever begin
      @(negedge clock_i);
      if (!have) begin
        cur  = (src_q.size() > 0) ? src_q.pop_front() : W'($urandom);
        have = 1'b1;
      end
      if (stall_left > 0) begin
        data_valid_i = 1'b0;
        stall_left--;
      end else begin
        data_valid_i = ($urandom_range(99) >= stall_pct);
      end
      data_i = cur;
      if (data_valid_i && data_ready_o && reset_ni) begin
        exp_words.push_back(cur);
        have = 1'b0;
      end
    end
  end

  // Monitor plus behavioural shift block (loads on tx_load, shifts MSB-first on SCLK falling edges).
  initial begin
    logic [W-1:0] tx_sr, rx;
    int tx_cnt, bits, loads, hi_cnt, n;
    logic prev_sclk, done_prev, mosi;
    tx_sr = '0; rx = '0; tx_cnt = 0; bits = 0; loads = 0; hi_cnt = 0;
    prev_sclk = 1'b0; done_prev = 1'b0; mosi = 1'b0;
    tx_done_i = 1'b0;
    forever begin
      @(negedge clock_i);
      if (!reset_ni) begin
        tx_cnt = 0; bits = 0; loads = 0; hi_cnt = 0; rises_in_frame = 0;
        prev_sclk = 1'b0; done_prev = 1'b0; tx_done_i = 1'b0;
        continue;
      end
      if (SCLK_o && !prev_sclk) begin
        chk("cs_low_at_rise", 32'(CS_n_o), 0);
        rx = {rx[W-2:0], mosi};
        bits++;
        rises_in_frame++;
        hi_cnt = 0;
        if (bits == W) begin
          bits = 0;
          if (exp_words.size() == 0) fail_now("unexpected_word");
          else chk("mosi_word", 32'(rx), 32'(exp_words.pop_front()));
        end
      end
      if (SCLK_o) hi_cnt++;
      if (!SCLK_o && prev_sclk) chk("sclk_high_clocks", 32'(hi_cnt), CD);
      if (SCLK_o) chk("sclk_only_with_en", 32'(tx_en_o), 1);
      if (tx_en_o) chk("cs_low_while_en", 32'(CS_n_o), 0);
      if (data_ready_o && !data_valid_i) chk("stall_pins", {29'd0, CS_n_o, SCLK_o, tx_en_o}, 0);
      if (tx_load_o) begin
        loads++;
        chk("load_en_low", 32'(tx_en_o), 0);
        if (exp_words.size() == 0) fail_now("load_without_word");
        else chk("load_data", 32'(tx_buffer_o), 32'(exp_words[0]));
      end
      if (done_o) begin
        chk("done_one_cycle", 32'(done_prev), 0);
        if (exp_frames.size() == 0) fail_now("unexpected_done");
        else begin
          n = exp_frames.pop_front();
          chk("words_sent", 32'(words_sent_o), n);
          chk("frame_loads", loads, n);
          chk("frame_rises", rises_in_frame, W * n);
          chk("busy_at_done", 32'(busy_o), 0);
          chk("cs_at_done", 32'(CS_n_o), 1);
        end
        loads = 0;
        rises_in_frame = 0;
      end
      done_prev = done_o;
      if (tx_load_o) begin
        tx_sr = tx_buffer_o;
        tx_cnt = 0;
      end else if (!tx_en_o) begin
        tx_cnt = 0;
      end else if (prev_sclk && !SCLK_o) begin
        tx_sr = {tx_sr[W-2:0], 1'b0};
        tx_cnt++;
      end
      tx_done_i = (tx_cnt == W);
      mosi = tx_sr[W-1];
      prev_sclk = SCLK_o;
    end
  end

  task automatic start_frame(input int n);
    @(negedge clock_i);
    start_i = 1'b1;
    num_words_i = NW'(n);
    exp_frames.push_back((n > MW) ? MW : n);
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_o) break;
      @(negedge clock_i);
    end
    if (!done_o) fail_now("done_timeout");
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sclk"}, 32'(SCLK_o), 0);
    chk({tag, "_cs_n"}, 32'(CS_n_o), 1);
    chk({tag, "_tx_en"}, 32'(tx_en_o), 0);
    chk({tag, "_tx_load"}, 32'(tx_load_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_ready"}, 32'(data_ready_o), 0);
    chk({tag, "_words"}, 32'(words_sent_o), 0);
    chk({tag, "_buffer"}, 32'(tx_buffer_o), 0);
  endtask

  initial begin
    int gap, n;
    reset_ni = 1'b0;
    start_i = 1'b0;
    num_words_i = '0;
    repeat (3) @(negedge clock_i);
    check_idle("reset");
    reset_ni = 1'b1;

    // Single word 8'hA5.
    src_q.push_back(8'hA5);
    start_frame(1);
    wait_done(2000);

    // Three words with a forced upstream stall before the second.
    src_q.push_back(8'h01); src_q.push_back(8'h80); src_q.push_back(8'hFF);
    start_frame(3);
    for (int i = 0; i < 500 && !tx_en_o; i++) @(negedge clock_i);
    for (int i = 0; i < 500 && tx_en_o; i++) @(negedge clock_i);
    stall_left = 12;
    wait_done(3000);

    // Zero-length frame: done the cycle after start, no CS activity.
    start_frame(0);
    chk("zero_done", 32'(done_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk("zero_cs_idle", 32'(CS_n_o), 1);
      chk("zero_busy_idle", 32'(busy_o), 0);
      @(negedge clock_i);
    end

    // Over-length request is clipped to MAX_WORDS.
    start_frame(MW + 1);
    wait_done(5000);

    // Asynchronous reset in the middle of SHIFT.
    start_frame(2);
    for (int i = 0; i < 500 && rises_in_frame < 3; i++) @(negedge clock_i);
    if (rises_in_frame < 3) fail_now("third_rise_timeout");
    @(posedge clock_i);
    #3 reset_ni = 1'b0;
    exp_words.delete();
    exp_frames.delete();
    #1 check_idle("async_reset");
    repeat (2) @(negedge clock_i);
    reset_ni = 1'b1;
    start_frame(1);
    wait_done(2000);

    // start_i held high across two frames.
    exp_frames.push_back(2);
    exp_frames.push_back(2);
    @(negedge clock_i);
    start_i = 1'b1;
    num_words_i = NW'(2);
    wait_done(3000);
    gap = 0;
    @(negedge clock_i);
    for (int i = 0; i < 20 && !busy_o; i++) begin
      gap++;
      @(negedge clock_i);
    end
    chk("busy_gap_between_frames", 32'(gap >= 1), 1);
    wait_done(3000);
    start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    chk("no_queued_start", 32'(busy_o), 0);

    // Random frames with random upstream stalls.
    stall_pct = 25;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, MW + 1);
      start_frame(n);
      wait_done(n * 300 + 200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
